// File: rtl/div_issuer.sv
// Single-outstanding divide issuer: accepts a command, launches it on an external
// divider, waits for the result or a timeout, and returns a tagged response.
module div_issuer #(
   parameter int BW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic          i_cmd_signed,
   input  logic [BW-1:0] i_cmd_num,
   input  logic [BW-1:0] i_cmd_den,
   input  logic [4:0]    i_cmd_tag,
   output logic          o_div_wr,
   output logic          o_div_signed,
   output logic [BW-1:0] o_div_num,
   output logic [BW-1:0] o_div_den,
   input  logic          i_div_busy,
   input  logic          i_div_valid,
   input  logic          i_div_err,
   input  logic [BW-1:0] i_div_quotient,
   input  logic [3:0]    i_div_flags,
   output logic          o_res_valid,
   input  logic          i_res_ready,
   output logic [BW-1:0] o_res_data,
   output logic [3:0]    o_res_flags,
   output logic          o_res_err,
   output logic          o_res_timeout,
   output logic [4:0]    o_res_tag,
   output logic          o_proto_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          r_wr_d;
   logic          r_div_signed;
   logic [BW-1:0] r_div_num, r_div_den;
   logic [BW-1:0] r_res_data;
   logic [3:0]    r_res_flags;
   logic          r_res_err, r_res_timeout;
   logic [4:0]    r_res_tag;
   logic          r_proto_err;
   logic          w_accept;
   logic          w_wait_last;

   assign w_accept    = i_cmd_valid && o_cmd_ready;
   assign w_wait_last = (r_cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = (i_cmd_den != '0) ? S_ISSUE : S_RESP;
         S_ISSUE: if (!i_div_busy) w_next = S_WAIT;
         S_WAIT:  if (i_div_valid || w_wait_last) w_next = S_RESP;
         S_RESP:  if (i_res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Ready is masked while reset is held so every output reads 0 during reset.
   always_comb begin
      o_cmd_ready = (r_state == S_IDLE) && i_reset_n;
      o_div_wr    = (r_state == S_ISSUE) && !i_div_busy;
      o_res_valid = (r_state == S_RESP);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt         <= '0;
         r_wr_d        <= 1'b0;
         r_div_signed  <= 1'b0;
         r_div_num     <= '0;
         r_div_den     <= '0;
         r_res_data    <= '0;
         r_res_flags   <= '0;
         r_res_err     <= 1'b0;
         r_res_timeout <= 1'b0;
         r_res_tag     <= '0;
         r_proto_err   <= 1'b0;
      end else begin
         r_wr_d <= o_div_wr;
         if (w_accept) begin
            r_div_signed  <= i_cmd_signed;
            r_div_num     <= i_cmd_num;
            r_div_den     <= i_cmd_den;
            r_res_tag     <= i_cmd_tag;
            r_res_data    <= '0;
            r_res_flags   <= '0;
            r_res_err     <= (i_cmd_den == '0);
            r_res_timeout <= 1'b0;
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            if (i_div_valid) begin
               r_res_data    <= i_div_quotient;
               r_res_flags   <= i_div_flags;
               r_res_err     <= i_div_err;
               r_res_timeout <= 1'b0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
               if (w_wait_last) begin
                  r_res_data    <= '0;
                  r_res_flags   <= '0;
                  r_res_err     <= 1'b1;
                  r_res_timeout <= 1'b1;
               end
            end
         end
         // Sticky flag for any divider handshake violation.
         if ((i_div_valid && r_state != S_WAIT) || (r_wr_d && !i_div_busy) ||
             (i_div_busy && i_div_valid) || (i_div_err && !i_div_valid))
            r_proto_err <= 1'b1;
      end
   end

   assign o_div_signed  = r_div_signed;
   assign o_div_num     = r_div_num;
   assign o_div_den     = r_div_den;
   assign o_res_data    = r_res_data;
   assign o_res_flags   = r_res_flags;
   assign o_res_err     = r_res_err;
   assign o_res_timeout = r_res_timeout;
   assign o_res_tag     = r_res_tag;
   assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_div_issuer.sv
// Randomized bench for div_issuer: a cycle-driven divider model feeds the DUT and a
// spec-level result model predicts each tagged response.
module tb_div_issuer;

   localparam int BW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          i_reset_n;
   logic          i_cmd_valid, i_cmd_signed;
   logic [BW-1:0] i_cmd_num, i_cmd_den;
   logic [4:0]    i_cmd_tag;
   logic          o_cmd_ready, o_div_wr, o_div_signed;
   logic [BW-1:0] o_div_num, o_div_den;
   logic          i_div_busy, i_div_valid, i_div_err;
   logic [BW-1:0] i_div_quotient;
   logic [3:0]    i_div_flags;
   logic          o_res_valid, i_res_ready;
   logic [BW-1:0] o_res_data;
   logic [3:0]    o_res_flags;
   logic          o_res_err, o_res_timeout;
   logic [4:0]    o_res_tag;
   logic          o_proto_err;

   always #5 clk = ~clk;

   div_issuer #(.BW(BW), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_reset_n(i_reset_n),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_signed(i_cmd_signed), .i_cmd_num(i_cmd_num), .i_cmd_den(i_cmd_den),
      .i_cmd_tag(i_cmd_tag),
      .o_div_wr(o_div_wr), .o_div_signed(o_div_signed),
      .o_div_num(o_div_num), .o_div_den(o_div_den),
      .i_div_busy(i_div_busy), .i_div_valid(i_div_valid), .i_div_err(i_div_err),
      .i_div_quotient(i_div_quotient), .i_div_flags(i_div_flags),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
      .o_res_data(o_res_data), .o_res_flags(o_res_flags),
      .o_res_err(o_res_err), .o_res_timeout(o_res_timeout),
      .o_res_tag(o_res_tag), .o_proto_err(o_proto_err)
   );

   typedef struct {
      logic [BW-1:0] data;
      logic [3:0]    flags;
      logic          err;
      logic          tmo;
      logic [4:0]    tag;
   } res_t;

   res_t exp_q[$];
   res_t last_res;
   int   n_cmp = 0;
   int   n_mis = 0;
   logic exp_proto = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [BW-1:0] div_quot(input logic sgn, input logic [BW-1:0] n,
                                              input logic [BW-1:0] d);
      if (d == '0) return '0;
      if (sgn) return BW'($signed(n) / $signed(d));
      return n / d;
   endfunction

   // Expected response from the command and what the divider did.
   function automatic res_t ref_result(input logic [BW-1:0] den, input logic [4:0] tag,
                                       input bit timed_out, input logic [BW-1:0] q,
                                       input logic [3:0] fl, input logic er);
      res_t r;
      r.tag = tag;
      if (den == '0) begin
         r.data = '0; r.flags = '0; r.err = 1'b1; r.tmo = 1'b0;
      end else if (timed_out) begin
         r.data = '0; r.flags = '0; r.err = 1'b1; r.tmo = 1'b1;
      end else begin
         r.data = q; r.flags = fl; r.err = er; r.tmo = 1'b0;
      end
      return r;
   endfunction

   task automatic idle_inputs();
      i_cmd_valid = 0; i_cmd_signed = 0; i_cmd_num = '0; i_cmd_den = '0; i_cmd_tag = '0;
      i_div_busy = 0; i_div_valid = 0; i_div_err = 0; i_div_quotient = '0; i_div_flags = '0;
      i_res_ready = 0;
   endtask

   // lat: divider busy for lat WAIT cycles then valid; lat >= TO means it never answers.
   task automatic run_cmd(input logic sgn, input logic [BW-1:0] num, input logic [BW-1:0] den,
                          input logic [4:0] tag, input int busy_pre, input int lat,
                          input int ready_wait);
      logic [BW-1:0] q;
      logic [3:0]    fl;
      logic          er;
      res_t          e;
      int            wait_cycles;
      bit            got_resp;
      q  = div_quot(sgn, num, den);
      fl = 4'($urandom);
      er = ($urandom_range(0, 3) == 0);
      exp_q.push_back(ref_result(den, tag, lat >= TO, q, fl, er));

      @(negedge clk);
      i_cmd_valid = 1; i_cmd_signed = sgn; i_cmd_num = num; i_cmd_den = den; i_cmd_tag = tag;
      #1 check("cmd_ready", o_cmd_ready, 1);
      @(negedge clk);
      i_cmd_valid = 0; i_cmd_signed = 1'($urandom); i_cmd_num = $urandom;
      i_cmd_den = $urandom; i_cmd_tag = 5'($urandom);
      if (den == '0) begin
         #1;
         check("fast_valid", o_res_valid, 1);
         check("fast_no_wr", o_div_wr, 0);
      end else begin
         for (int i = 0; i < busy_pre; i++) begin
            i_div_busy = 1;
            #1;
            check("wr_while_busy", o_div_wr, 0);
            check("hold_num_issue", o_div_num, num);
            @(negedge clk);
         end
         i_div_busy = 0;
         #1;
         check("wr_pulse", o_div_wr, 1);
         check("div_num", o_div_num, num);
         check("div_den", o_div_den, den);
         check("div_signed", o_div_signed, sgn);
         check("no_res_in_issue", o_res_valid, 0);
         wait_cycles = 0;
         got_resp = 0;
         for (int k = 0; k < TO + 8; k++) begin
            @(negedge clk);
            if (o_res_valid) begin
               got_resp = 1;
               break;
            end
            wait_cycles++;
            i_div_busy     = (k < lat);
            i_div_valid    = (k == lat);
            i_div_quotient = (k == lat) ? q : BW'($urandom);
            i_div_flags    = (k == lat) ? fl : 4'($urandom);
            i_div_err      = (k == lat) ? er : 1'b0;
            #1;
            check("wr_in_wait", o_div_wr, 0);
            check("hold_den_wait", o_div_den, den);
         end
         check("resp_reached", 64'(got_resp), 1);
         check("wait_cycles", 64'(wait_cycles), (lat < TO) ? 64'(lat + 1) : 64'(TO));
         i_div_busy = 0; i_div_valid = 0; i_div_err = 0;
      end

      e = exp_q.pop_front();
      last_res = e;
      for (int i = 0; i <= ready_wait; i++) begin
         if (i > 0) @(negedge clk);
         i_res_ready = (i == ready_wait);
         #1;
         check("res_valid", o_res_valid, 1);
         check("cmd_ready_in_resp", o_cmd_ready, 0);
         check("res_data", o_res_data, e.data);
         check("res_flags", o_res_flags, e.flags);
         check("res_err", o_res_err, e.err);
         check("res_timeout", o_res_timeout, e.tmo);
         check("res_tag", o_res_tag, e.tag);
      end
      @(negedge clk);
      i_res_ready = 0;
      #1;
      check("cmd_ready_after", o_cmd_ready, 1);
      check("res_valid_after", o_res_valid, 0);
      check("proto_err", o_proto_err, exp_proto);
   endtask

   task automatic stray_valid();
      @(negedge clk);
      i_div_busy = 0; i_div_valid = 1; i_div_quotient = $urandom; i_div_flags = 4'hF;
      @(negedge clk);
      i_div_valid = 0; i_div_flags = '0;
      exp_proto = 1;
      #1;
      check("stray_proto", o_proto_err, 1);
      check("stray_no_valid", o_res_valid, 0);
      check("stray_cmd_ready", o_cmd_ready, 1);
      check("stray_data", o_res_data, last_res.data);
      check("stray_flags", o_res_flags, last_res.flags);
      check("stray_timeout", o_res_timeout, last_res.tmo);
   endtask

   task automatic reset_in_wait();
      @(negedge clk);
      i_cmd_valid = 1; i_cmd_signed = 0; i_cmd_num = 32'd9; i_cmd_den = 32'd3; i_cmd_tag = 5'd21;
      @(negedge clk);
      i_cmd_valid = 0; i_div_busy = 0;
      @(negedge clk);
      i_div_busy = 1;
      @(negedge clk);
      i_reset_n = 0;
      #1;
      check("rst_cmd_ready", o_cmd_ready, 0);
      check("rst_div_wr", o_div_wr, 0);
      check("rst_div_num", o_div_num, 0);
      check("rst_div_den", o_div_den, 0);
      check("rst_res_valid", o_res_valid, 0);
      check("rst_res_tag", o_res_tag, 0);
      check("rst_res_err", o_res_err, 0);
      check("rst_proto", o_proto_err, 0);
      i_div_busy = 0;
      @(negedge clk);
      @(negedge clk);
      i_reset_n = 1;
      exp_proto = 0;
      #1 check("rst_release_ready", o_cmd_ready, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (o_res_valid !== 1'b0 || o_div_wr !== 1'b0) begin
            check("rst_no_result", {o_res_valid, o_div_wr}, 0);
            break;
         end
      end
      check("rst_idle_after", o_res_valid, 0);
   endtask

   initial begin
      logic [BW-1:0] den;
      int            lat;
      idle_inputs();
      i_reset_n = 0;
      #1;
      check("reset_cmd_ready", o_cmd_ready, 0);
      check("reset_res_valid", o_res_valid, 0);
      check("reset_proto", o_proto_err, 0);
      @(negedge clk);
      @(negedge clk);
      i_reset_n = 1;
      #1;
      check("post_reset_ready", o_cmd_ready, 1);
      check("post_reset_wr", o_div_wr, 0);

      run_cmd(1'b0, 32'd100, 32'd7, 5'd3, 0, 3, 0);
      check("q_100_7", last_res.data, 14);
      run_cmd(1'b1, 32'd5, 32'd0, 5'd9, 0, 1, 0);
      run_cmd(1'b0, 32'd50, 32'd5, 5'd1, 4, 2, 0);
      run_cmd(1'b1, 32'hFFFF_FFEC, 32'd3, 5'd7, 0, 5, 5);
      run_cmd(1'b0, 32'd1000, 32'd10, 5'd30, 1, TO - 1, 1);
      run_cmd(1'b0, 32'd77, 32'd8, 5'd12, 1, 1000, 2);
      stray_valid();
      reset_in_wait();

      for (int n = 0; n < 40; n++) begin
         den = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom_range(1, 5000));
         lat = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(1, TO - 1));
         run_cmd(1'($urandom), $urandom, den, 5'($urandom), int'($urandom_range(0, 4)), lat,
                 int'($urandom_range(0, 5)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/div_issuer.md
DIV_ISSUER -- requirements
Module: div_issuer

Interface
REQ-001 SHALL have parameter BW, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 64, max divider wait cycles (TIMEOUT >= 4).
REQ-003 SHALL have ports:
  i_clk  in  1  single clock; one clock; reset is asynchronous and active-low.
  i_reset_n  in  1  asynchronous active-low reset.
  i_cmd_valid  in  1  command request.
  o_cmd_ready  out  1  command accepted when i_cmd_valid && o_cmd_ready.
  i_cmd_signed  in  1  signed divide.
  i_cmd_num, i_cmd_den  in  BW  numerator, denominator.
  i_cmd_tag  in  5  destination register tag.
  o_div_wr  out  1  divider start strobe.
  o_div_signed  out  1  to divider.
  o_div_num, o_div_den  out  BW  to divider.
  i_div_busy, i_div_valid, i_div_err  in  1  divider status.
  i_div_quotient  in  BW  divider result.
  i_div_flags  in  4  divider flags.
  o_res_valid  out  1  result available.
  i_res_ready  in  1  result consumed when o_res_valid && i_res_ready.
  o_res_data  out  BW  quotient.
  o_res_flags  out  4  flags.
  o_res_err, o_res_timeout  out  1  error / timeout indication.
  o_res_tag  out  5  echoed tag.
  o_proto_err  out  1  sticky divider-protocol violation.

Function
REQ-004 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; o_cmd_ready = (state == IDLE).
REQ-005 On accept in IDLE SHALL register signed/num/den/tag into o_div_* and o_res_tag; next state ISSUE if den != 0, else RESP.
REQ-006 Den == 0 fast path: SHALL NOT pulse o_div_wr; o_res_valid rises the cycle after accept with o_res_err=1, o_res_timeout=0, o_res_data=0, o_res_flags=0.
REQ-007 In ISSUE, o_div_wr SHALL be high for exactly one cycle, and only when i_div_busy is low; while i_div_busy is high, remain in ISSUE with o_div_wr low.
REQ-008 After the o_div_wr cycle SHALL enter WAIT with timeout counter cleared.
REQ-009 In WAIT, on i_div_valid SHALL capture i_div_quotient, i_div_flags and i_div_err into o_res_data/o_res_flags/o_res_err, set o_res_timeout=0, go to RESP; o_res_valid high the next cycle.
REQ-010 In WAIT, counter SHALL increment each cycle without i_div_valid; when it reaches TIMEOUT-1 SHALL go to RESP with o_res_err=1, o_res_timeout=1, data=0, flags=0.
REQ-011 In RESP, o_res_valid SHALL be high and all o_res_* stable until i_res_ready; on handshake SHALL return to IDLE (o_cmd_ready high the following cycle).
REQ-012 o_div_wr and o_res_valid SHALL be combinational functions of state only, never of upstream inputs.
REQ-013 o_proto_err SHALL set and stay set on: i_div_valid outside WAIT; i_div_busy low the cycle after o_div_wr; i_div_busy && i_div_valid same cycle; i_div_err without i_div_valid.
REQ-014 An i_div_valid outside WAIT (e.g. after timeout) SHALL NOT alter o_res_* or state.
REQ-015 At most one divide SHALL be outstanding; o_div_num/den/signed SHALL hold constant from accept until leaving WAIT.

Reset
REQ-016 i_reset_n low SHALL immediately force IDLE, counter 0, and all outputs 0 except o_cmd_ready, which is 1 after reset deassertion.
REQ-017 Reset mid-operation SHALL discard the in-flight command with no result produced; o_proto_err cleared only by reset.

Verification
REQ-018 Unsigned 100/7, tag 3; divider model busy 3 cycles then valid, quotient 14, flags 0 -> o_div_wr single pulse, o_res_valid with data 14, err 0, tag 3.
REQ-019 Signed 5/0 -> no o_div_wr; o_res_valid the cycle after accept, err 1, timeout 0, data 0.
REQ-020 TIMEOUT=16, divider never valid -> o_res_valid after 16 WAIT cycles, err 1, timeout 1; later stray i_div_valid sets o_proto_err, o_res_* unchanged.
REQ-021 i_div_busy held high 4 cycles at ISSUE -> o_div_wr asserted the first cycle busy is low, never while busy.
REQ-022 i_res_ready low 5 cycles in RESP -> o_res_* stable, o_cmd_ready low; handshake -> IDLE next cycle.
REQ-023 i_reset_n pulsed low during WAIT -> all outputs 0 in the same cycle, no result emitted, o_cmd_ready 1 after release.
